instr_mem_loader: RTL and testbench

- Instruction memory that sits directly upstream of the core's instruction fetch port.
- A boot-loader FSM fills it from a byte stream and holds the core in reset until the load completes.
- The read side serves the core's instruction fetch stage with a registered read of 1-cycle latency.
- The load side accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words and writes them from word 0 upward.

---
 rtl/instr_mem_loader_pkg.sv | 20 ++
 rtl/instr_mem_loader_sram.sv | 27 ++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 tb/tb_instr_mem_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared types and constants for the boot-loaded instruction memory
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} loader_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Lanes below 'lane' come from the held bytes, 'data' optionally fills 'lane', upper lanes are zero
    function automatic logic [31:0] pack_word(input logic [23:0] held, input logic [1:0] lane,
                                              input logic [7:0] data, input logic with_data);
        logic [31:0] word;
        word = '0;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(lane)) word[8*k +: 8] = held[8*k +: 8];
        end
        if (with_data) word[{lane, 3'b000} +: 8] = data;
        return word;
    endfunction

endpackage

// File: rtl/instr_mem_loader_sram.sv
// rtl/instr_mem_loader_sram.sv - instr_sram: one write port, one registered read-first read port
module instr_sram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset so a reload only overwrites what it reaches
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream boot loader into instruction memory; INSTR_LOADER_CHECKSUM_EN adds a trailing checksum byte
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [7:0]      load_data,
    input  logic            load_last,
    input  logic [31:0]     instr_rd_addr,
    output logic [31:0]     instr_rd_data,
    output logic            core_rst_n,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] load_words
);

    loader_state_t state;
    logic [1:0]    lane;
    logic [23:0]   held;
    logic          overflow;
    logic          xfer;
    logic          at_full;
    logic          payload;
    logic          store;
    logic          fail;
    logic          we;
    logic [31:0]   wdata;
    logic          rd_oob;
    logic          rd_oob_q;
    logic [31:0]   sram_rdata;
    logic          unused_addr_bits;

    assign load_ready = (state == IDLE) || (state == LOAD);
    assign load_done  = (state == RUN);
    assign xfer       = load_valid && load_ready;
    // load_words doubles as the write pointer; with a power-of-two depth its MSB alone means full
    assign at_full    = load_words[ADDR_W];

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    assign payload = !load_last;
    assign fail    = overflow || (sum != load_data);

    always_comb begin
        we    = 1'b0;
        wdata = pack_word(held, lane, load_data, payload);
        if (xfer) begin
            if (load_last) we = !fail && (lane != 2'd0);
            else           we = !at_full && (lane == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)               sum <= '0;
        else if (xfer && payload) sum <= sum + load_data;
    end
`else
    assign payload = 1'b1;
    assign fail    = overflow || at_full;

    always_comb begin
        we    = xfer && !at_full && ((lane == 2'd3) || load_last);
        wdata = pack_word(held, lane, load_data, 1'b1);
    end
`endif

    assign store = xfer && payload && !at_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lane       <= 2'd0;
            held       <= '0;
            overflow   <= 1'b0;
            load_words <= '0;
            load_err   <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            core_rst_n <= (state == RUN);
            if (store) begin
                case (lane)
                    2'd0:    held[7:0]   <= load_data;
                    2'd1:    held[15:8]  <= load_data;
                    2'd2:    held[23:16] <= load_data;
                    default: ;
                endcase
                lane <= lane + 2'd1;
            end
            // Bytes past the end are dropped but still accepted so the stream drains
            if (xfer && payload && at_full) overflow <= 1'b1;
            if (we) load_words <= load_words + (ADDR_W + 1)'(1);
            if (xfer) begin
                if (load_last) begin
                    if (fail) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end else begin
                        state    <= RUN;
                    end
                end else if (state == IDLE) begin
                    state <= LOAD;
                end
            end
        end
    end

    assign rd_oob           = |instr_rd_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^instr_rd_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) rd_oob_q <= 1'b0;
        else        rd_oob_q <= rd_oob;
    end

    assign instr_rd_data = rd_oob_q ? NOP_INSTR : sram_rdata;

    instr_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (load_words[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (instr_rd_addr[ADDR_W+1:2]),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized and directed bench for instr_mem_loader against a byte-count model
module tb_instr_mem_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic [31:0] instr_rd_addr = 32'h0;
    logic        load_ready;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [31:0] instr_rd_data;
    logic [AW:0] load_words;

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .instr_rd_addr (instr_rd_addr),
        .instr_rd_data (instr_rd_data),
        .core_rst_n    (core_rst_n),
        .load_done     (load_done),
        .load_err      (load_err),
        .load_words    (load_words)
    );

    int errors = 0;
    int checks = 0;
    bit rand_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: image tracked as a count of stored payload bytes; a word lands once complete or on the final byte
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_pend [4];
    int          m_cnt = 0;
    int          m_words = 0;
    bit          m_ovf = 1'b0, m_run = 1'b0, m_err = 1'b0, m_core = 1'b0;
    logic [7:0]  m_sum = 8'h00;
    logic [31:0] m_rd = 32'h0;
    bit          m_rd_known = 1'b0;

    task automatic m_commit();
        int w, n;
        logic [31:0] word;
        w = (m_cnt - 1) / 4;
        n = (m_cnt - 1) % 4 + 1;
        word = 32'h0;
        for (int k = 0; k < n; k++) word[8*k +: 8] = m_pend[k];
        m_mem[w]   = word;
        m_known[w] = 1'b1;
        m_words    = w + 1;
    endtask

    task automatic m_byte(input logic [7:0] d, input bit last);
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (last) begin
            if (!m_ovf && m_sum == d) begin
                if (m_cnt % 4 != 0) m_commit();
                m_run = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            return;
        end
        m_sum = m_sum + d;
        if (m_cnt >= 4 * DEPTH) m_ovf = 1'b1;
        else begin
            m_pend[m_cnt % 4] = d;
            m_cnt++;
            if (m_cnt % 4 == 0) m_commit();
        end
`else
        if (m_cnt >= 4 * DEPTH) m_ovf = 1'b1;
        else begin
            m_pend[m_cnt % 4] = d;
            m_cnt++;
            if (m_cnt % 4 == 0 || last) m_commit();
        end
        if (last) begin
            if (m_ovf) m_err = 1'b1;
            else       m_run = 1'b1;
        end
`endif
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0; m_words = 0; m_ovf = 1'b0; m_run = 1'b0; m_err = 1'b0;
            m_core = 1'b0; m_sum = 8'h00; m_rd = 32'h0; m_rd_known = 1'b1;
        end else begin
            m_core = m_run;
            if (instr_rd_addr[31:AW+2] != 0) begin
                m_rd = 32'h00000013;
                m_rd_known = 1'b1;
            end else begin
                m_rd = m_mem[instr_rd_addr[AW+1:2]];
                m_rd_known = m_known[instr_rd_addr[AW+1:2]];
            end
            if (load_valid && !m_run && !m_err) m_byte(load_data, load_last);
        end
    end

    initial forever begin
        @(negedge clk);
        check("load_ready", 32'(load_ready), 32'(!(m_run || m_err)));
        check("load_done",  32'(load_done),  32'(m_run));
        check("load_err",   32'(load_err),   32'(m_err));
        check("core_rst_n", 32'(core_rst_n), 32'(m_core));
        check("load_words", 32'(load_words), 32'(m_words));
        if (m_rd_known) check("instr_rd_data", instr_rd_data, m_rd);
    end

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return (32'd1 << $urandom_range(31, AW + 2)) | 32'($urandom_range(0, 31));
        return 32'($urandom_range(0, 4 * DEPTH - 1));
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_rd) instr_rd_addr = rand_addr();
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int gap);
        repeat (gap) tick();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        instr_rd_addr = a;
        tick();
        check(name, instr_rd_data, exp);
    endtask

    initial begin
        logic [7:0] img [8];
        logic [7:0] s;
        int len;

        repeat (3) tick();
        check("rst core_rst_n", 32'(core_rst_n), 32'h0);
        check("rst load_done",  32'(load_done),  32'h0);
        check("rst load_err",   32'(load_err),   32'h0);
        check("rst load_words", 32'(load_words), 32'h0);
        check("rst rd_data",    instr_rd_data,   32'h0);
        check("rst load_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;
        tick();

`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 1); send(8'h03, 1'b0, 0); send(8'h06, 1'b1, 2);
        check("ck good done", 32'(load_done), 32'h1);
        tick();
        check("ck good words", 32'(load_words), 32'h1);
        rd(32'h0, 32'h00030201, "ck good mem0");

        do_reset();
        send(8'h01, 1'b0, 0); send(8'h02, 1'b0, 0); send(8'h03, 1'b0, 0); send(8'h07, 1'b1, 0);
        check("ck bad err", 32'(load_err), 32'h1);
        check("ck bad done", 32'(load_done), 32'h0);

        do_reset();
        send(8'h00, 1'b1, 1);
        check("ck lone done", 32'(load_done), 32'h1);
        check("ck lone words", 32'(load_words), 32'h0);

        do_reset();
        s = 8'h00;
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            send(8'(i + 1), 1'b0, 0);
            s = s + 8'(i + 1);
        end
        check("ck ovf ready", 32'(load_ready), 32'h1);
        send(s, 1'b1, 0);
        check("ck ovf err", 32'(load_err), 32'h1);
        check("ck ovf words", 32'(load_words), 32'(DEPTH));
`else
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_reset();
        for (int i = 0; i < 8; i++) send(img[i], i == 7, 0);
        check("t1 done edge", 32'(load_done), 32'h1);
        check("t1 core still low", 32'(core_rst_n), 32'h0);
        tick();
        check("t1 core released", 32'(core_rst_n), 32'h1);
        check("t1 words", 32'(load_words), 32'h2);
        check("t1 ready low", 32'(load_ready), 32'h0);
        rd(32'h4, 32'h00100093, "t1 mem1");
        rd(32'h0, 32'h00000013, "t1 mem0");
        rd(32'h6, 32'h00100093, "t1 low bits ignored");
        rd(32'h0001_0000, 32'h00000013, "t1 oob nop");
        rd(32'h0001_0004, 32'h00000013, "t1 oob nop w1");

        do_reset();
        send(8'h01, 1'b0, 2); send(8'h02, 1'b0, 0); send(8'h03, 1'b0, 1);
        send(8'h04, 1'b0, 0); send(8'hAA, 1'b1, 2);
        check("t2 done", 32'(load_done), 32'h1);
        check("t2 words", 32'(load_words), 32'h2);
        rd(32'h4, 32'h000000AA, "t2 mem1 padded");
        rd(32'h0, 32'h04030201, "t2 mem0");

        do_reset();
        for (int i = 0; i < 4 * DEPTH + 3; i++) send(8'(i + 1), 1'b0, 0);
        check("t3 ready draining", 32'(load_ready), 32'h1);
        send(8'hEE, 1'b1, 0);
        check("t3 ready after", 32'(load_ready), 32'h0);
        check("t3 err", 32'(load_err), 32'h1);
        repeat (3) tick();
        check("t3 core held", 32'(core_rst_n), 32'h0);
        check("t3 words", 32'(load_words), 32'(DEPTH));
        rd(32'((DEPTH - 1) * 4), {8'(4 * DEPTH), 8'(4 * DEPTH - 1), 8'(4 * DEPTH - 2), 8'(4 * DEPTH - 3)}, "t3 last word");

        do_reset();
        send(8'hA1, 1'b0, 0); send(8'hA2, 1'b0, 0); send(8'hA3, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        check("t4 core in reset", 32'(core_rst_n), 32'h0);
        check("t4 idle ready", 32'(load_ready), 32'h1);
        check("t4 words cleared", 32'(load_words), 32'h0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i), i == 7, 0);
        check("t4 words", 32'(load_words), 32'h2);
        rd(32'h0, 32'h14131211, "t4 mem0 restarted");
        rd(32'h4, 32'h18171615, "t4 mem1");
`endif

        rand_rd = 1'b1;
        for (int it = 0; it < 30; it++) begin
            do_reset();
            len = $urandom_range(1, 4 * DEPTH + 6);
            s = 8'h00;
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                bit last;
                if (i > 0 && $urandom_range(0, 40) == 0) break;
                last = (i == len - 1);
                d = 8'($urandom);
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (last && $urandom_range(0, 1) == 1) d = s;
`endif
                s = s + d;
                send(d, last, $urandom_range(0, 2));
            end
            repeat (4) tick();
        end
        rand_rd = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
